raifes_per_uart_txq: RTL and testbench

// - AHB-Lite peripheral slave on the per_* bus, sitting directly upstream of raifes_uart.
// - Buffers bytes written by the core in a FIFO and feeds them one at a time to the UART transmitter.
// - Uses the transmitter's send_strobe/ready handshake, so software no longer has to poll the UART per byte.

---
 rtl/raifes_per_uart_txq_pkg.sv | 58 +++++
 rtl/raifes_per_uart_txq_sync_fifo.sv | 79 +++++++
 rtl/raifes_per_uart_txq.sv | 170 +++++++++++++++++
 tb/tb_raifes_per_uart_txq.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/raifes_per_uart_txq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package    : raifes_per_uart_txq_pkg                                      |
// | Description: Shared constants, types and helpers for the UART TX queue.   |
// |              It holds the bus widths, the STAT register bit positions,    |
// |              the drain FSM state codes and a STAT word packing helper.    |
// | Revision   : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
package raifes_per_uart_txq_pkg;

  // HASTI bus widths.
  localparam int unsigned c_hasti_addr_width = 32;
  localparam int unsigned c_hasti_bus_width  = 32;

  // Address bit that selects between DATA (0x0) and STAT (0x4).
  localparam int unsigned c_reg_sel_bit = 2;

  // STAT register layout.
  localparam int unsigned c_stat_empty_bit = 0;
  localparam int unsigned c_stat_full_bit  = 1;
  localparam int unsigned c_stat_ovf_bit   = 2;
  localparam int unsigned c_stat_cnt_lsb   = 3;
  localparam int unsigned c_stat_cnt_msb   = 9;
  localparam int unsigned c_stat_ie_bit    = 8;

  // Drain FSM state codes.
  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_send = 2'd1;
  localparam logic [1:0] c_st_hold = 2'd2;

  // Captured address phase, consumed one cycle later in the data phase.
  typedef struct packed {
    logic valid;
    logic sel;
    logic wr;
  } txq_aphase_t;

  // Packs the STAT word. The IE bit shares the count field's upper range,
  // which is always zero for depths up to 16 entries.
  function automatic logic [31:0] stat_word(
    input logic [6:0] count,
    input logic       ie,
    input logic       ovf,
    input logic       full,
    input logic       empty
  );
    logic [31:0] w;
    w = '0;
    w[c_stat_cnt_msb:c_stat_cnt_lsb] = count;
    w[c_stat_ie_bit]    = w[c_stat_ie_bit] | ie;
    w[c_stat_ovf_bit]   = ovf;
    w[c_stat_full_bit]  = full;
    w[c_stat_empty_bit] = empty;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/raifes_per_uart_txq_sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : raifes_sync_fifo                                             |
// | Description: Single-clock FIFO, 2**DEPTH_LOG2 entries of WIDTH bits.      |
// |              A push to a full FIFO is accepted only when a pop happens    |
// |              in the same cycle; otherwise it is dropped and flagged.      |
// | Ports      : CLKout, RESET (async, active-high)                           |
// |              push/wdata  - write request and data                         |
// |              pop         - remove head entry (ignored when empty)         |
// |              full/empty/count/head - occupancy and head-of-queue data     |
// |              push_dropped - one-cycle flag, push refused because full     |
// | Revision   : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module raifes_sync_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  CLKout,
  input  logic                  RESET,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic [WIDTH-1:0]      head,
  output logic                  push_dropped
);

  localparam int unsigned             c_depth      = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]     c_count_full = (DEPTH_LOG2 + 1)'(c_depth);
  localparam logic [DEPTH_LOG2:0]     c_count_one  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0]   c_ptr_one    = (DEPTH_LOG2)'(1);

  logic [WIDTH-1:0]      r_mem [c_depth];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_pop;
  logic                  w_push;

  assign full         = (r_count == c_count_full);
  assign empty        = (r_count == '0);
  assign count        = r_count;
  assign head         = r_mem[r_rd_ptr];
  assign w_pop        = pop & ~empty;
  // A simultaneous pop frees a slot, so a full FIFO can still take the push.
  assign w_push       = push & (~full | w_pop);
  assign push_dropped = push & full & ~w_pop;

  // Storage needs no reset: the pointers define which entries are valid.
  always_ff @(posedge CLKout) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge CLKout or posedge RESET) begin
    if (RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_count_one;
        2'b01:   r_count <= r_count - c_count_one;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/raifes_per_uart_txq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : raifes_per_uart_txq                                          |
// | Description: AHB-Lite slave that queues bytes for raifes_uart and feeds   |
// |              them out with the send_strobe/ready handshake.               |
// | Ports      : CLKout, RESET (async, active-high)                           |
// |              per_* - HASTI slave port (zero wait states, always OKAY)     |
// |              tx_data/tx_strobe - byte and one-cycle send pulse to UART    |
// |              tx_ready          - UART idle indication                     |
// |              irq               - only with RAIFES_UART_TXQ_IRQ_EN         |
// | Registers  : 0x0 DATA  W: push hwdata[7:0]             R: 0              |
// |              0x4 STAT  R: count[9:3] IE[8] ovf[2] full[1] empty[0]       |
// |                        W: hwdata[2]=1 clears ovf, hwdata[8] -> IE         |
// | Config     : `define RAIFES_UART_TXQ_IRQ_EN adds the IE bit and irq port. |
// | Revision   : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module raifes_per_uart_txq
  import raifes_per_uart_txq_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                          CLKout,
  input  logic                          RESET,
  input  logic                          per_en,
  input  logic [c_hasti_addr_width-1:0] per_haddr,
  input  logic                          per_hwrite,
  input  logic [1:0]                    per_htrans,
  input  logic [c_hasti_bus_width-1:0]  per_hwdata,
  output logic [c_hasti_bus_width-1:0]  per_hrdata,
  output logic                          per_hready,
  output logic                          per_hresp,
  output logic [7:0]                    tx_data,
  output logic                          tx_strobe,
  input  logic                          tx_ready
`ifdef RAIFES_UART_TXQ_IRQ_EN
  ,
  output logic                          irq
`endif
);

  txq_aphase_t         r_ap;
  logic [1:0]          r_state;
  logic                r_overflow;
  logic                r_tx_strobe;
  logic [7:0]          r_tx_data;
  logic                w_push;
  logic                w_pop;
  logic                w_stat_wr;
  logic                w_stat_rd;
  logic                w_full;
  logic                w_empty;
  logic [DEPTH_LOG2:0] w_count;
  logic [7:0]          w_head;
  logic                w_push_dropped;
  logic                w_ie;
  logic                w_unused_ok;

  assign per_hready = 1'b1;
  assign per_hresp  = 1'b0;

  // Address phase capture.
  always_ff @(posedge CLKout or posedge RESET) begin
    if (RESET) begin
      r_ap <= '0;
    end else begin
      r_ap.valid <= per_en & per_htrans[1] & per_hready;
      r_ap.sel   <= per_haddr[c_reg_sel_bit];
      r_ap.wr    <= per_hwrite;
    end
  end

  assign w_push    = r_ap.valid &  r_ap.wr & ~r_ap.sel;
  assign w_stat_wr = r_ap.valid &  r_ap.wr &  r_ap.sel;
  assign w_stat_rd = r_ap.valid & ~r_ap.wr &  r_ap.sel;
  // The head entry leaves the FIFO during the single SEND cycle.
  assign w_pop     = (r_state == c_st_send);

  raifes_sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .CLKout       (CLKout),
    .RESET        (RESET),
    .push         (w_push),
    .wdata        (per_hwdata[7:0]),
    .pop          (w_pop),
    .full         (w_full),
    .empty        (w_empty),
    .count        (w_count),
    .head         (w_head),
    .push_dropped (w_push_dropped)
  );

  always_ff @(posedge CLKout or posedge RESET) begin
    if (RESET) begin
      r_overflow <= 1'b0;
    end else if (w_push_dropped) begin
      r_overflow <= 1'b1;
    end else if (w_stat_wr & per_hwdata[c_stat_ovf_bit]) begin
      r_overflow <= 1'b0;
    end
  end

  // Drain FSM. The strobe and data are registered on the IDLE->SEND
  // transition so both are valid exactly while the FSM sits in SEND. HOLD
  // skips the cycle in which the UART is still lowering its ready flag.
  always_ff @(posedge CLKout or posedge RESET) begin
    if (RESET) begin
      r_state     <= c_st_idle;
      r_tx_strobe <= 1'b0;
      r_tx_data   <= 8'h00;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (~w_empty & tx_ready) begin
            r_state     <= c_st_send;
            r_tx_strobe <= 1'b1;
            r_tx_data   <= w_head;
          end
        end
        c_st_send: begin
          r_state     <= c_st_hold;
          r_tx_strobe <= 1'b0;
        end
        c_st_hold: begin
          r_state <= c_st_idle;
        end
        default: begin
          r_state     <= c_st_idle;
          r_tx_strobe <= 1'b0;
        end
      endcase
    end
  end

  assign tx_strobe = r_tx_strobe;
  assign tx_data   = r_tx_data;

`ifdef RAIFES_UART_TXQ_IRQ_EN
  logic r_ie;
  logic r_irq;

  always_ff @(posedge CLKout or posedge RESET) begin
    if (RESET) begin
      r_ie  <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      if (w_stat_wr) begin
        r_ie <= per_hwdata[c_stat_ie_bit];
      end
      r_irq <= r_ie & w_empty & (r_state == c_st_idle);
    end
  end

  assign w_ie = r_ie;
  assign irq  = r_irq;
`else
  assign w_ie = 1'b0;
`endif

  assign per_hrdata = w_stat_rd
                    ? stat_word(7'(w_count), w_ie, r_overflow, w_full, w_empty)
                    : '0;

  // Bus bits that carry no meaning for this peripheral.
  assign w_unused_ok = ^{per_haddr[c_hasti_addr_width-1:3], per_haddr[1:0],
                         per_htrans[0], per_hwdata[c_hasti_bus_width-1:8]};

endmodule
`default_nettype wire

// File: tb/tb_raifes_per_uart_txq.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_raifes_per_uart_txq                                       |
// | Description: Self-checking bench for raifes_per_uart_txq. A queue-based   |
// |              reference holds the bytes that must appear on tx_data, plus  |
// |              the sticky overflow and IE flags; STAT is rebuilt from them. |
// |              Define RAIFES_UART_TXQ_IRQ_EN to also exercise irq.          |
// | Revision   : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module tb_raifes_per_uart_txq;

  localparam int DEPTH = 16;

  logic        CLKout = 1'b0;
  logic        RESET  = 1'b1;
  logic        per_en = 1'b0;
  logic [31:0] per_haddr = '0;
  logic        per_hwrite = 1'b0;
  logic [1:0]  per_htrans = 2'b00;
  logic [31:0] per_hwdata = '0;
  logic [31:0] per_hrdata;
  logic        per_hready;
  logic        per_hresp;
  logic [7:0]  tx_data;
  logic        tx_strobe;
  logic        tx_ready = 1'b0;
  logic        irq_w;

  raifes_per_uart_txq #(.DEPTH_LOG2(4)) dut (
    .CLKout     (CLKout),
    .RESET      (RESET),
    .per_en     (per_en),
    .per_haddr  (per_haddr),
    .per_hwrite (per_hwrite),
    .per_htrans (per_htrans),
    .per_hwdata (per_hwdata),
    .per_hrdata (per_hrdata),
    .per_hready (per_hready),
    .per_hresp  (per_hresp),
    .tx_data    (tx_data),
    .tx_strobe  (tx_strobe),
    .tx_ready   (tx_ready)
`ifdef RAIFES_UART_TXQ_IRQ_EN
    ,
    .irq        (irq_w)
`endif
  );
`ifndef RAIFES_UART_TXQ_IRQ_EN
  assign irq_w = 1'b0;
`endif

  always #5 CLKout = ~CLKout;

  int          checks = 0;
  int          errors = 0;
  byte unsigned q[$];
  bit          m_ovf = 0;
  bit          m_ie  = 0;
  int          cyc = 0;
  int          last_strobe_cyc = -1000;
  int          n_strobes = 0;
  int          min_gap = 1000;
  bit          rdy = 0;
  bit          prev_ready = 0;
  bit          dp_data_wr = 0;
  bit          dp_stat_wr = 0;
  logic [31:0] s_rdata;
  logic [31:0] s_exp_stat;
  logic        s_irq;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_stat();
    int n;
    n = q.size();
    return (32'(n) << 3) | (m_ie ? 32'h100 : 32'h0) | (m_ovf ? 32'h4 : 32'h0) |
           ((n == DEPTH) ? 32'h2 : 32'h0) | ((n == 0) ? 32'h1 : 32'h0);
  endfunction

  // One clock cycle: sample at the falling edge, update the reference with
  // what happens on the next rising edge, then drive the next address phase
  // together with the data for the current data phase.
  task automatic step(input bit av, input bit asel, input bit awr, input logic [31:0] wdata);
    bit full_before;
    @(negedge CLKout);
    cyc++;
    s_rdata     = per_hrdata;
    s_exp_stat  = model_stat();
    s_irq       = irq_w;
    full_before = (q.size() == DEPTH);
    if (tx_strobe === 1'b1) begin
      n_strobes++;
      check("strobe_after_ready", 32'(prev_ready), 32'd1);
      if (cyc - last_strobe_cyc < min_gap) min_gap = cyc - last_strobe_cyc;
      last_strobe_cyc = cyc;
      if (q.size() == 0) check("spurious_strobe", 32'(tx_strobe), 32'd0);
      else               check("tx_data_order", 32'(tx_data), 32'(q.pop_front()));
    end
    if (dp_data_wr) begin
      if (!full_before || tx_strobe === 1'b1) q.push_back(wdata[7:0]);
      else m_ovf = 1;
    end
    if (dp_stat_wr) begin
      if (wdata[2]) m_ovf = 0;
`ifdef RAIFES_UART_TXQ_IRQ_EN
      m_ie = wdata[8];
`endif
    end
    per_hwdata = wdata;
    per_en     = av;
    per_htrans = av ? 2'b10 : 2'($urandom_range(0, 3));
    per_haddr  = ($urandom & 32'hFFFF_FFFB) | (asel ? 32'h4 : 32'h0);
    per_hwrite = awr;
    tx_ready   = rdy;
    prev_ready = rdy;
    dp_data_wr = av & awr & !asel;
    dp_stat_wr = av & awr & asel;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 32'h0);
  endtask

  task automatic wr(input bit sel, input logic [31:0] d);
    step(1, sel, 1, 32'h0);
    step(0, 0, 0, d);
  endtask

  task automatic rd_stat(output logic [31:0] obs, output logic [31:0] exp);
    step(1, 1, 0, 32'h0);
    step(0, 0, 0, 32'h0);
    obs = s_rdata;
    exp = s_exp_stat;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    q.delete();
    m_ovf = 0;
    m_ie  = 0;
    dp_data_wr = 0;
    dp_stat_wr = 0;
    idle(3);
    RESET = 1'b0;
  endtask

  initial begin
    logic [31:0] o, e;
    int d, s0;

    // Reset state
    idle(3);
    check("rst_strobe", 32'(tx_strobe), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h0);
    check("rst_hrdata", per_hrdata, 32'h0);
    check("hready", 32'(per_hready), 32'd1);
    check("hresp", 32'(per_hresp), 32'd0);
    check("rst_irq", 32'(irq_w), 32'd0);
    RESET = 1'b0;
    rd_stat(o, e);
    check("stat_after_reset", o, 32'h1);
    rdy = 1;
    idle(100);
    check("no_strobe_idle", 32'(n_strobes), 32'd0);
    step(1, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0);
    check("data_read_zero", s_rdata, 32'h0);
    check("hrdata_idle_zero", per_hrdata, 32'h0);

    // Single byte: strobe seen on the second falling edge after the data phase
    wr(0, 32'h41);
    d = cyc;
    idle(6);
    check("single_strobe_count", 32'(n_strobes), 32'd1);
    check("strobe_latency", 32'(last_strobe_cyc - d), 32'd2);
    check("tx_data_hold", 32'(tx_data), 32'h41);
    rd_stat(o, e);
    check("stat_empty_after_send", o, 32'h1);

    // Fill, overflow, drain in order
    rdy = 0;
    for (int i = 0; i < 16; i++) wr(0, 32'(i));
    rd_stat(o, e);
    check("stat_full", o, 32'h82);
    wr(0, 32'hFF);
    rd_stat(o, e);
    check("stat_overflow", o, 32'h86);
    s0 = n_strobes;
    rdy = 1;
    idle(70);
    check("drain16_count", 32'(n_strobes - s0), 32'd16);
    rd_stat(o, e);
    check("stat_ovf_sticky", o, 32'h5);
    wr(1, 32'h4);
    rd_stat(o, e);
    check("stat_ovf_cleared", o, 32'h1);

    // Push coinciding with the SEND pop: 15 entries, then 16 (full)
    rdy = 0;
    for (int i = 0; i < 15; i++) wr(0, 32'h50 + 32'(i));
    rd_stat(o, e);
    check("stat_15", o, 32'h78);
    rdy = 1;
    step(1, 0, 1, 32'h0);
    rdy = 0;
    step(0, 0, 0, 32'hA0);
    check("pop_in_push_cycle_15", 32'(last_strobe_cyc), 32'(cyc));
    idle(3);
    rd_stat(o, e);
    check("stat_15_after_pushpop", o, 32'h78);
    wr(0, 32'hA1);
    rd_stat(o, e);
    check("stat_16", o, 32'h82);
    rdy = 1;
    step(1, 0, 1, 32'h0);
    rdy = 0;
    step(0, 0, 0, 32'hA2);
    check("pop_in_push_cycle_16", 32'(last_strobe_cyc), 32'(cyc));
    idle(3);
    rd_stat(o, e);
    check("stat_full_no_ovf", o, 32'h82);
    check("stat_model_full", o, e);
    rdy = 1;
    idle(80);
    check("drain_pushpop", 32'(q.size()), 32'd0);

    // Randomized traffic against the reference queue
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: wr(0, 32'($urandom_range(0, 255)));
        5, 6: begin
          rd_stat(o, e);
          check("rand_stat", o, e);
        end
        7: rdy = 1'($urandom_range(0, 1));
        8: idle($urandom_range(1, 4));
        default: wr(1, $urandom & 32'h0000_0104);
      endcase
    end
    rdy = 1;
    idle(80);
    check("rand_drain", 32'(q.size()), 32'd0);
    rd_stat(o, e);
    check("rand_final_stat", o, e);

    // Reset with bytes queued flushes them
    rdy = 0;
    for (int i = 0; i < 5; i++) wr(0, 32'hC0 + 32'(i));
    s0 = n_strobes;
    do_reset();
    rd_stat(o, e);
    check("stat_after_midreset", o, 32'h1);
    rdy = 1;
    idle(20);
    check("no_strobe_after_flush", 32'(n_strobes - s0), 32'd0);

`ifdef RAIFES_UART_TXQ_IRQ_EN
    // Interrupt on drained queue
    wr(1, 32'h100);
    rd_stat(o, e);
    check("stat_ie", o, 32'h101);
    check("irq_idle_empty", 32'(irq_w), 32'd1);
    rdy = 0;
    wr(0, 32'h11);
    wr(0, 32'h22);
    idle(2);
    check("irq_low_queued", 32'(s_irq), 32'd0);
    s0 = n_strobes;
    rdy = 1;
    for (int k = 0; k < 40 && n_strobes < s0 + 2; k++) step(0, 0, 0, 32'h0);
    check("irq_drain_strobes", 32'(n_strobes - s0), 32'd2);
    idle(1);
    check("irq_hold_0", 32'(s_irq), 32'd0);
    idle(1);
    check("irq_hold_1", 32'(s_irq), 32'd0);
    idle(1);
    check("irq_rise", 32'(s_irq), 32'd1);
    wr(0, 32'h33);
    check("irq_push_cycle", 32'(s_irq), 32'd1);
    idle(1);
    check("irq_before_fall", 32'(s_irq), 32'd1);
    idle(1);
    check("irq_fall", 32'(s_irq), 32'd0);
    idle(10);
`endif

    check("strobe_gap_min", 32'(min_gap >= 3), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
